decoder_scan_sequencer: RTL and testbench
=========================================

// Module: decoder_scan_sequencer
// PURPOSE
//   Generates the select code that drives the 3-to-8 decoder, walking it through every
//   code in order and holding each code for a set number of cycles.
//   Used for LED or row scanning and for chip-select sweeps, directly upstream of decoder3to8.
//   Supports single-pass or continuous scanning, up or down direction, and abort.
// PARAMETERS
//   SEL_W    3   select width; scan covers codes 0 .. 2**SEL_W-1
//   DWELL_W  8   width of the dwell-count input
// PORTS
//   clk        in   1        single clock, rising edge
//   rst        in   1        synchronous, active-high reset
//   start      in   1        1-cycle request to begin a scan; ignored while busy
//   stop       in   1        abort request; honoured in any state
//   dir_down   in   1        0: ascending codes, 1: descending; sampled at start only
//   wrap_en    in   1        1: scan continuously, 0: single pass; sampled at start only
//   dwell      in   DWELL_W  hold cycles minus 1 per code (0 -> 1 cycle); sampled at start
//   sel        out  SEL_W    select code to the decoder's A input; registered
//   sel_valid  out  1        sel is meaningful; the decoder enable/qualifier
//   step       out  1        1-cycle pulse on every cycle in which sel takes a new value
//   busy       out  1        high in RUN
//   done       out  1        1-cycle pulse when a single pass completes normally
// BEHAVIOUR
//   - Reset: state=IDLE; sel=0, sel_valid=0, step=0, busy=0, done=0; dwell counter=0.
//     Reset overrides every other input, including mid-scan.
//   - All outputs are registered. Nothing is combinational from input to output.
//   - FSM has two states: IDLE and RUN.
//   - IDLE, start=1 and stop=0:
//     - Latch dir_down, wrap_en and dwell.
//     - Next cycle: sel = 0 (up) or 2**SEL_W-1 (down); sel_valid=1, busy=1, step=1.
//     - Go to RUN. Latency from start to the first sel is 1 cycle.
//   - IDLE, start=1 and stop=1: stop wins; stay in IDLE with no output change.
//   - RUN: each code is held for dwell_q+1 cycles. Counter loads dwell_q on every step and
//     decrements to 0. At 0:
//     - Not the last code: sel +/- 1, step=1.
//     - Last code (2**SEL_W-1 up, 0 down) with wrap_en_q=1: sel wraps modulo 2**SEL_W, step=1.
//     - Last code with wrap_en_q=0: next cycle sel_valid=0, busy=0, done=1; go to IDLE.
//       sel keeps its last value.
//   - RUN, stop=1: next cycle IDLE; sel_valid=0, busy=0, done=0, step=0.
//     This holds even if stop coincides with the final dwell expiry; no done pulse.
//   - start while in RUN is ignored. dwell, dir_down and wrap_en changes during RUN are ignored.
//   - done and start arriving in the same cycle: the new start is accepted on the next IDLE cycle.
//     done never overlaps busy.
//   - Width rules: sel arithmetic is unsigned, modulo 2**SEL_W. Counter is DWELL_W bits;
//     dwell = all-ones gives 2**DWELL_W cycles per code.
// STRUCTURE
//   - Shared package (scan_pkg): FSM state localparams (ST_IDLE, ST_RUN) and the default
//     SEL_W/DWELL_W constants, reused by the decoder tests.
//   - One sub-module, dwell_counter:
//     - Inputs: load, load_val, en.
//     - Output: expired flag (count==0 while enabled).
//   - The FSM and sel register live in the top module.
//   - The bench instantiates decoder_scan_sequencer feeding decoder3to8 and checks D == 1<<sel
//     whenever sel_valid=1.
// TESTING
//   1. Up, single pass, dwell=0:
//      - start at cycle 0 -> sel = 0,1,...,7 on cycles 1..8.
//      - step=1 on each of those cycles, done=1 at cycle 9, busy=0 at cycle 9.
//   2. Down, dwell=2:
//      - sel = 7,6,...,0, each held exactly 3 cycles.
//      - done 24 cycles after the first sel; D walks 0x80 -> 0x01.
//   3. Wrap up, dwell=1:
//      - After 7 comes 0 with step=1 and no done.
//      - stop mid-scan -> next cycle sel_valid=0, busy=0, done never pulses.
//   4. Edge cases:
//      - start and stop together in IDLE -> nothing happens.
//      - start pulsed during RUN -> scan unaffected.
//      - dwell changed during RUN -> hold time unchanged.
//   5. Reset at sel=5 mid-dwell -> next cycle all outputs 0, state IDLE.
//      A fresh start afterwards begins at 0.
//   6. stop on the exact cycle the final code's dwell expires (wrap_en=0) -> no done pulse;
//      returns to IDLE.

Source files
------------

// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared constants and FSM states for the decoder scan sequencer
package scan_pkg;

    localparam int SEL_W_DEF   = 3;
    localparam int DWELL_W_DEF = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/decoder3to8.sv
// rtl/decoder3to8.sv - one-hot 3-to-8 decoder with active-high enable
module decoder3to8 (
    input  logic [2:0] a,
    input  logic       en,
    output logic [7:0] d
);

    always_comb begin
        d = 8'h00;
        if (en) begin
            d[a] = 1'b1;
        end
    end

endmodule

// File: rtl/dwell_counter.sv
// rtl/dwell_counter.sv - per-code hold counter; loads on each step, counts down to zero
module dwell_counter #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               en,
    output logic               expired
);

    logic [DWELL_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - DWELL_W'(1);
        end
    end

    assign expired = en && (count == '0);

endmodule

// File: rtl/decoder_scan_sequencer.sv
// rtl/decoder_scan_sequencer.sv - walks a decoder select code through all values with a programmable dwell
module decoder_scan_sequencer
    import scan_pkg::*;
#(
    parameter int SEL_W   = SEL_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               dir_down,
    input  logic               wrap_en,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   sel,
    output logic               sel_valid,
    output logic               step,
    output logic               busy,
    output logic               done
);

    scan_state_t        state_q, state_d;
    logic               dir_down_q, wrap_en_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               latch_cfg;

    logic [SEL_W-1:0]   sel_d;
    logic               sel_valid_d, step_d, busy_d, done_d;

    logic               cnt_load, cnt_en, cnt_expired;
    logic [DWELL_W-1:0] cnt_load_val;

    logic [SEL_W-1:0]   sel_next;
    logic               sel_is_last;

    assign sel_next    = dir_down_q ? (sel - SEL_W'(1)) : (sel + SEL_W'(1));
    assign sel_is_last = dir_down_q ? (sel == '0) : (sel == '1);

    dwell_counter #(
        .DWELL_W (DWELL_W)
    ) u_dwell_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .expired  (cnt_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            dir_down_q <= 1'b0;
            wrap_en_q  <= 1'b0;
            dwell_q    <= '0;
            sel        <= '0;
            sel_valid  <= 1'b0;
            step       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel       <= sel_d;
            sel_valid <= sel_valid_d;
            step      <= step_d;
            busy      <= busy_d;
            done      <= done_d;
            if (latch_cfg) begin
                dir_down_q <= dir_down;
                wrap_en_q  <= wrap_en;
                dwell_q    <= dwell;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel;
        sel_valid_d  = sel_valid;
        step_d       = 1'b0;
        busy_d       = busy;
        done_d       = 1'b0;
        latch_cfg    = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = dwell_q;
        cnt_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    // Config registers update at this same edge, so seed from the live inputs.
                    latch_cfg    = 1'b1;
                    state_d      = ST_RUN;
                    sel_d        = dir_down ? '1 : '0;
                    sel_valid_d  = 1'b1;
                    busy_d       = 1'b1;
                    step_d       = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = dwell;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d     = ST_IDLE;
                    sel_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end else begin
                    cnt_en = 1'b1;
                    if (cnt_expired) begin
                        if (sel_is_last && !wrap_en_q) begin
                            // sel deliberately keeps the final code after a completed pass.
                            state_d     = ST_IDLE;
                            sel_valid_d = 1'b0;
                            busy_d      = 1'b0;
                            done_d      = 1'b1;
                        end else begin
                            sel_d    = sel_next;
                            step_d   = 1'b1;
                            cnt_load = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// tb/tb_decoder_scan_sequencer.sv - directed vector bench for the scan sequencer driving decoder3to8
module tb_decoder_scan_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       dir_down;
    logic       wrap_en;
    logic [7:0] dwell;
    logic [2:0] sel;
    logic       sel_valid;
    logic       step;
    logic       busy;
    logic       done;
    logic [7:0] d;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       start;
        logic       stop;
        logic       dir_down;
        logic       wrap_en;
        logic [7:0] dwell;
        logic [2:0] e_sel;
        logic       e_valid;
        logic       e_step;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t vecs[$];

    decoder_scan_sequencer #(
        .SEL_W   (3),
        .DWELL_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .dir_down  (dir_down),
        .wrap_en   (wrap_en),
        .dwell     (dwell),
        .sel       (sel),
        .sel_valid (sel_valid),
        .step      (step),
        .busy      (busy),
        .done      (done)
    );

    decoder3to8 u_dec (
        .a  (sel),
        .en (sel_valid),
        .d  (d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock and sample #1 after the edge; the decoder is checked on every cycle.
    task automatic tick();
        logic [7:0] exp_d;
        @(posedge clk);
        #1;
        exp_d = sel_valid ? (8'h01 << sel) : 8'h00;
        check("decoder_d", d, exp_d);
    endtask

    task automatic drive(input logic st, input logic sp, input logic dn,
                         input logic wr, input logic [7:0] dw);
        start    = st;
        stop     = sp;
        dir_down = dn;
        wrap_en  = wr;
        dwell    = dw;
    endtask

    task automatic check_outs(input string tag, input logic [2:0] e_sel, input logic e_valid,
                              input logic e_step, input logic e_busy, input logic e_done);
        check({tag, ".sel"},       {5'd0, sel},       {5'd0, e_sel});
        check({tag, ".sel_valid"}, {7'd0, sel_valid}, {7'd0, e_valid});
        check({tag, ".step"},      {7'd0, step},      {7'd0, e_step});
        check({tag, ".busy"},      {7'd0, busy},      {7'd0, e_busy});
        check({tag, ".done"},      {7'd0, done},      {7'd0, e_done});
    endtask

    task automatic add_vec(input logic st, input logic sp, input logic dn, input logic wr,
                           input logic [7:0] dw, input logic [2:0] es, input logic ev,
                           input logic estp, input logic eb, input logic ed);
        vec_t v;
        v.start = st; v.stop = sp; v.dir_down = dn; v.wrap_en = wr; v.dwell = dw;
        v.e_sel = es; v.e_valid = ev; v.e_step = estp; v.e_busy = eb; v.e_done = ed;
        vecs.push_back(v);
    endtask

    initial begin
        int done_seen;

        drive(0, 0, 0, 0, 8'd0);
        rst = 1'b1;
        tick();
        tick();
        check_outs("reset", 3'd0, 0, 0, 0, 0);
        rst = 1'b0;

        // Each row: inputs during a cycle, expected registered outputs in the following cycle.
        add_vec(1, 1, 0, 0, 8'd0, 3'd0, 0, 0, 0, 0);  // start+stop in IDLE: nothing
        add_vec(1, 0, 0, 0, 8'd0, 3'd0, 1, 1, 1, 0);  // up, single pass, dwell 0
        add_vec(0, 0, 0, 0, 8'd5, 3'd1, 1, 1, 1, 0);  // dwell change mid-run ignored
        add_vec(1, 0, 1, 1, 8'd5, 3'd2, 1, 1, 1, 0);  // start/dir/wrap mid-run ignored
        add_vec(0, 0, 0, 0, 8'd5, 3'd3, 1, 1, 1, 0);
        add_vec(0, 0, 0, 0, 8'd5, 3'd4, 1, 1, 1, 0);
        add_vec(0, 0, 0, 0, 8'd5, 3'd5, 1, 1, 1, 0);
        add_vec(0, 0, 0, 0, 8'd5, 3'd6, 1, 1, 1, 0);
        add_vec(0, 0, 0, 0, 8'd5, 3'd7, 1, 1, 1, 0);
        add_vec(0, 0, 0, 0, 8'd5, 3'd7, 0, 0, 0, 1);  // pass complete: done, sel held
        add_vec(1, 0, 1, 0, 8'd0, 3'd7, 1, 1, 1, 0);  // start during done cycle accepted
        add_vec(0, 0, 0, 0, 8'd0, 3'd6, 1, 1, 1, 0);
        add_vec(0, 1, 0, 0, 8'd0, 3'd6, 0, 0, 0, 0);  // stop in RUN
        add_vec(0, 0, 0, 0, 8'd0, 3'd6, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].start, vecs[i].stop, vecs[i].dir_down, vecs[i].wrap_en, vecs[i].dwell);
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].e_sel, vecs[i].e_valid,
                       vecs[i].e_step, vecs[i].e_busy, vecs[i].e_done);
        end
        drive(0, 0, 0, 0, 8'd0);
        tick();

        // Down, dwell=2: each code held 3 cycles, done 24 cycles after the first sel.
        drive(1, 0, 1, 0, 8'd2);
        tick();
        drive(0, 0, 0, 0, 8'd0);
        check("down.first_d", d, 8'h80);
        for (int c = 7; c >= 0; c--) begin
            for (int h = 0; h < 3; h++) begin
                if (!(c == 7 && h == 0)) tick();
                check_outs($sformatf("down.c%0d.h%0d", c, h), 3'(c), 1, (h == 0), 1, 0);
            end
        end
        check("down.last_d", d, 8'h01);
        tick();
        check_outs("down.done", 3'd0, 0, 0, 0, 1);
        tick();
        check_outs("down.after", 3'd0, 0, 0, 0, 0);

        // Wrap up, dwell=1: 7 -> 0 with a step and no done, then stop mid-scan.
        drive(1, 0, 0, 1, 8'd1);
        tick();
        drive(0, 0, 0, 0, 8'd0);
        done_seen = 0;
        for (int n = 0; n < 16; n++) begin
            tick();
            if (done) done_seen++;
        end
        check_outs("wrap.to0", 3'd0, 1, 1, 1, 0);
        tick();
        check_outs("wrap.hold0", 3'd0, 1, 0, 1, 0);
        tick();
        check_outs("wrap.sel1", 3'd1, 1, 1, 1, 0);
        drive(0, 1, 0, 0, 8'd0);
        tick();
        drive(0, 0, 0, 0, 8'd0);
        check_outs("wrap.stop", 3'd1, 0, 0, 0, 0);
        for (int n = 0; n < 4; n++) begin
            tick();
            if (done) done_seen++;
        end
        check("wrap.no_done", 8'(done_seen), 8'd0);

        // Reset at sel=5 mid-dwell, then a fresh start begins at code 0.
        drive(1, 0, 0, 0, 8'd3);
        tick();
        drive(0, 0, 0, 0, 8'd3);
        for (int n = 0; n < 21; n++) tick();
        check_outs("rst.pre", 3'd5, 1, 0, 1, 0);
        rst = 1'b1;
        tick();
        check_outs("rst.mid", 3'd0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        check_outs("rst.idle", 3'd0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 8'd0);
        tick();
        drive(0, 0, 0, 0, 8'd0);
        check_outs("rst.restart", 3'd0, 1, 1, 1, 0);
        tick();
        check_outs("rst.restart1", 3'd1, 1, 1, 1, 0);
        drive(0, 1, 0, 0, 8'd0);
        tick();
        drive(0, 0, 0, 0, 8'd0);

        // Stop coinciding with the final code's dwell expiry: no done pulse.
        drive(1, 0, 0, 0, 8'd1);
        tick();
        drive(0, 0, 0, 0, 8'd0);
        for (int n = 0; n < 15; n++) tick();
        check_outs("lastexp.pre", 3'd7, 1, 0, 1, 0);
        drive(0, 1, 0, 0, 8'd0);
        tick();
        drive(0, 0, 0, 0, 8'd0);
        check_outs("lastexp.stop", 3'd7, 0, 0, 0, 0);
        tick();
        check_outs("lastexp.after", 3'd7, 0, 0, 0, 0);

        // Maximum dwell: all-ones holds each code for 256 cycles.
        drive(1, 0, 0, 0, 8'hFF);
        tick();
        drive(0, 0, 0, 0, 8'd0);
        for (int n = 0; n < 255; n++) tick();
        check_outs("maxdwell.hold", 3'd0, 1, 0, 1, 0);
        tick();
        check_outs("maxdwell.next", 3'd1, 1, 1, 1, 0);
        drive(0, 1, 0, 0, 8'd0);
        tick();
        drive(0, 0, 0, 0, 8'd0);
        check_outs("maxdwell.stop", 3'd1, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
